gpr_wport_arbiter: RTL and testbench

- Owns the single write port of the 32x32 general-purpose register file.
- Shares that port between three sources:
  - the writeback stage (highest priority, never stalled);
  - a debug write requester using a req/ack handshake;
  - an internal clear sequencer that zeroes x1..x31 after reset or on command.
- Sits between the WB pipeline stage, the debug module and the register file.
- Drives registered write-enable, address and data into the register file.

---
 rtl/gpr_wport_arbiter.sv | 123 ++++++++++++
 tb/tb_gpr_wport_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_wport_arbiter.sv
// Single write port of the 32x32 GPR file, shared by writeback, a debug requester
// and a clear sequencer. Write winner of cycle N is presented on the port in cycle N+1.
module gpr_wport_arbiter #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned NREGS          = 32,
    parameter int unsigned STARVE_LIMIT   = 8,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            RegWrite_WB,
    input  logic [4:0]      rd_wb,
    input  logic [XLEN-1:0] rd_wb_data,
    input  logic            dbg_req,
    input  logic [4:0]      dbg_addr,
    input  logic [XLEN-1:0] dbg_wdata,
    output logic            dbg_ack,
    input  logic            clr_req,
    output logic            clr_busy,
    output logic            clr_done,
    output logic            hold_o,
    output logic            gpr_we,
    output logic [4:0]      gpr_waddr,
    output logic [XLEN-1:0] gpr_wdata
);

    localparam int unsigned AW = 5;
    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

    localparam logic [AW-1:0] LAST_PTR   = AW'(NREGS - 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;
    localparam logic [0:0] ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    logic [0:0]      state, state_d;
    logic [AW-1:0]   clr_ptr, clr_ptr_d;
    logic [CW-1:0]   starve_cnt, starve_d;
    logic            ack_q;
    logic            ack_c;
    logic            wb_live;
    logic            we_d;
    logic [AW-1:0]   waddr_d;
    logic [XLEN-1:0] wdata_d;
    logic            done_d;

    // Arbitration: live WB > clear sequencer > debug (RUN only, one-cycle lockout after ack)
    always_comb begin
        state_d   = state;
        clr_ptr_d = clr_ptr;
        starve_d  = starve_cnt;
        we_d      = 1'b0;
        waddr_d   = gpr_waddr;
        wdata_d   = gpr_wdata;
        done_d    = 1'b0;
        ack_c     = 1'b0;
        wb_live   = RegWrite_WB && (rd_wb != '0);

        if (wb_live) begin
            we_d    = 1'b1;
            waddr_d = rd_wb;
            wdata_d = rd_wb_data;
        end else if (state == ST_CLEAR) begin
            we_d    = 1'b1;
            waddr_d = clr_ptr;
            wdata_d = '0;
            if (clr_ptr == LAST_PTR) begin
                clr_ptr_d = AW'(1);
                state_d   = ST_RUN;
                done_d    = 1'b1;
            end else begin
                clr_ptr_d = clr_ptr + AW'(1);
            end
        end else if (dbg_req && !ack_q) begin
            ack_c   = 1'b1;
            we_d    = (dbg_addr != '0);
            waddr_d = dbg_addr;
            wdata_d = dbg_wdata;
        end

        if ((state == ST_RUN) && clr_req) begin
            state_d = ST_CLEAR;
        end

        // Starvation counter saturates; any ack or dropped request clears it
        if (!dbg_req || ack_c) begin
            starve_d = '0;
        end else if (starve_cnt < STARVE_MAX) begin
            starve_d = starve_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_RESET;
            clr_ptr    <= AW'(1);
            starve_cnt <= '0;
            ack_q      <= 1'b0;
            gpr_we     <= 1'b0;
            gpr_waddr  <= '0;
            gpr_wdata  <= '0;
            clr_done   <= 1'b0;
            clr_busy   <= (ST_RESET == ST_CLEAR);
            hold_o     <= 1'b0;
        end else begin
            state      <= state_d;
            clr_ptr    <= clr_ptr_d;
            starve_cnt <= starve_d;
            ack_q      <= ack_c;
            gpr_we     <= we_d;
            gpr_waddr  <= waddr_d;
            gpr_wdata  <= wdata_d;
            clr_done   <= done_d;
            clr_busy   <= (state == ST_CLEAR);
            hold_o     <= (starve_d == STARVE_MAX);
        end
    end

    // Ack is issued in the arbitration cycle itself
    assign dbg_ack = rst_n && ack_c;

endmodule

// File: tb/tb_gpr_wport_arbiter.sv
// Bench for gpr_wport_arbiter: per-cycle behavioural model plus directed scenarios
// with literal expectations.
module tb_gpr_wport_arbiter;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned NREGS          = 32;
    localparam int unsigned STARVE_LIMIT   = 8;
    localparam int unsigned CLEAR_ON_RESET = 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            RegWrite_WB = 1'b0;
    logic [4:0]      rd_wb = '0;
    logic [XLEN-1:0] rd_wb_data = '0;
    logic            dbg_req = 1'b0;
    logic [4:0]      dbg_addr = '0;
    logic [XLEN-1:0] dbg_wdata = '0;
    logic            dbg_ack;
    logic            clr_req = 1'b0;
    logic            clr_busy;
    logic            clr_done;
    logic            hold_o;
    logic            gpr_we;
    logic [4:0]      gpr_waddr;
    logic [XLEN-1:0] gpr_wdata;

    always #5 clk = ~clk;

    gpr_wport_arbiter #(
        .XLEN(XLEN),
        .NREGS(NREGS),
        .STARVE_LIMIT(STARVE_LIMIT),
        .CLEAR_ON_RESET(CLEAR_ON_RESET)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .RegWrite_WB(RegWrite_WB),
        .rd_wb(rd_wb),
        .rd_wb_data(rd_wb_data),
        .dbg_req(dbg_req),
        .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack),
        .clr_req(clr_req),
        .clr_busy(clr_busy),
        .clr_done(clr_done),
        .hold_o(hold_o),
        .gpr_we(gpr_we),
        .gpr_waddr(gpr_waddr),
        .gpr_wdata(gpr_wdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: the port sees whoever owns the slot this cycle, one cycle later
    bit              m_clear;
    int              m_ptr;
    int              m_starve;
    bit              m_prev_ack;
    bit              have_exp = 1'b0;
    bit              e_we, e_ad, e_done, e_busy, e_hold;
    logic [4:0]      e_waddr;
    logic [XLEN-1:0] e_wdata;
    bit              live, ack_m, was_clear;

    always @(negedge clk) begin
        if (have_exp) begin
            chk("gpr_we", 64'(gpr_we), 64'(e_we));
            if (e_ad) begin
                chk("gpr_waddr", 64'(gpr_waddr), 64'(e_waddr));
                chk("gpr_wdata", 64'(gpr_wdata), 64'(e_wdata));
            end
            chk("clr_done", 64'(clr_done), 64'(e_done));
            chk("clr_busy", 64'(clr_busy), 64'(e_busy));
            chk("hold_o", 64'(hold_o), 64'(e_hold));
        end
        if (!rst_n) begin
            ack_m      = 1'b0;
            e_we       = 1'b0;
            e_ad       = 1'b1;
            e_waddr    = '0;
            e_wdata    = '0;
            e_done     = 1'b0;
            e_hold     = 1'b0;
            e_busy     = (CLEAR_ON_RESET != 0);
            m_clear    = (CLEAR_ON_RESET != 0);
            m_ptr      = 1;
            m_starve   = 0;
            m_prev_ack = 1'b0;
        end else begin
            live      = RegWrite_WB && (rd_wb != 5'd0);
            was_clear = m_clear;
            ack_m     = !m_clear && !live && dbg_req && !m_prev_ack;
            e_we      = 1'b0;
            e_ad      = 1'b0;
            e_done    = 1'b0;
            if (live) begin
                e_we = 1'b1; e_ad = 1'b1; e_waddr = rd_wb; e_wdata = rd_wb_data;
            end else if (m_clear) begin
                e_we = 1'b1; e_ad = 1'b1; e_waddr = 5'(m_ptr); e_wdata = '0;
                if (m_ptr == int'(NREGS) - 1) begin
                    e_done = 1'b1; m_ptr = 1; m_clear = 1'b0;
                end else begin
                    m_ptr++;
                end
            end else if (ack_m) begin
                e_we = (dbg_addr != 5'd0); e_ad = e_we; e_waddr = dbg_addr; e_wdata = dbg_wdata;
            end
            if (!was_clear && clr_req) m_clear = 1'b1;
            if (dbg_req && !ack_m) begin
                if (m_starve < int'(STARVE_LIMIT)) m_starve++;
            end else begin
                m_starve = 0;
            end
            e_hold     = (m_starve == int'(STARVE_LIMIT));
            e_busy     = was_clear;
            m_prev_ack = ack_m;
        end
        chk("dbg_ack", 64'(dbg_ack), 64'(ack_m));
        have_exp = 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RegWrite_WB = 1'b0; rd_wb = '0; rd_wb_data = '0;
        dbg_req = 1'b0; dbg_addr = '0; dbg_wdata = '0; clr_req = 1'b0;
    endtask

    initial begin
        int good, rise, ack_at, fall, n_we, n_wb, done_at, resume_addr, acks;
        bit done_seen, hold_seen;

        // Reset-triggered clear pass with no traffic
        idle();
        rst_n = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_we", 64'(gpr_we), 64'd0);
        chk("rst_busy", 64'(clr_busy), 64'd1);
        step();
        rst_n = 1'b1;
        good = 0;
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 32) begin
                if (gpr_we === 1'b1 && gpr_waddr == 5'(c - 1) && gpr_wdata == '0 &&
                    clr_done == (c == 32) && clr_busy === 1'b1) good++;
            end
            if (c == 33) begin
                chk("clr_busy_after", 64'(clr_busy), 64'd0);
                chk("clr_done_after", 64'(clr_done), 64'd0);
                chk("idle_we_after", 64'(gpr_we), 64'd0);
            end
            step();
        end
        chk("clear_seq", 64'(good), 64'd31);

        // Single debug write in RUN, request held through the lockout cycle
        dbg_req = 1'b1; dbg_addr = 5'd7; dbg_wdata = 32'h12345678;
        @(negedge clk);
        chk("dbg_ack_first", 64'(dbg_ack), 64'd1);
        step();
        @(negedge clk);
        chk("dbg_we", 64'(gpr_we), 64'd1);
        chk("dbg_waddr", 64'(gpr_waddr), 64'd7);
        chk("dbg_wdata", 64'(gpr_wdata), 64'h12345678);
        chk("dbg_ack_lockout", 64'(dbg_ack), 64'd0);
        step();
        idle();
        @(negedge clk);
        chk("lockout_no_write", 64'(gpr_we), 64'd0);
        step();

        // Debug starved by 12 cycles of live WB
        rise = 0; ack_at = 0; fall = 0;
        for (int c = 1; c <= 15; c++) begin
            RegWrite_WB = (c <= 12); rd_wb = 5'd3; rd_wb_data = 32'(c);
            dbg_req = (c <= 13); dbg_addr = 5'd11; dbg_wdata = 32'hCAFE0011;
            @(negedge clk);
            if (hold_o && rise == 0) rise = c;
            if (dbg_ack && ack_at == 0) ack_at = c;
            if (rise != 0 && !hold_o && fall == 0) fall = c;
            step();
        end
        idle();
        chk("hold_rise_cycle", 64'(rise), 64'd9);
        chk("starve_ack_cycle", 64'(ack_at), 64'd13);
        chk("hold_fall_cycle", 64'(fall), 64'd14);

        // WB to x0 does not take the slot
        RegWrite_WB = 1'b1; rd_wb = 5'd0; rd_wb_data = 32'hBAD0BAD0;
        dbg_req = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'hA5A5A5A5;
        @(negedge clk);
        chk("x0wb_dbg_ack", 64'(dbg_ack), 64'd1);
        step();
        idle();
        @(negedge clk);
        chk("x0wb_dbg_waddr", 64'(gpr_waddr), 64'd9);
        chk("x0wb_dbg_wdata", 64'(gpr_wdata), 64'hA5A5A5A5);
        step();

        // Debug write to x0: acked, no write
        dbg_req = 1'b1; dbg_addr = 5'd0; dbg_wdata = 32'h11111111;
        @(negedge clk);
        chk("dbg_x0_ack", 64'(dbg_ack), 64'd1);
        step();
        idle();
        @(negedge clk);
        chk("dbg_x0_no_we", 64'(gpr_we), 64'd0);
        step();

        // clr_req together with a debug grant; debug held through the clear
        dbg_req = 1'b1; dbg_addr = 5'd12; dbg_wdata = 32'h0000BEEF; clr_req = 1'b1;
        @(negedge clk);
        chk("clr_dbg_ack", 64'(dbg_ack), 64'd1);
        step();
        clr_req = 1'b0;
        @(negedge clk);
        chk("clr_dbg_waddr", 64'(gpr_waddr), 64'd12);
        chk("clr_dbg_wdata", 64'(gpr_wdata), 64'h0000BEEF);
        step();
        @(negedge clk);
        chk("clr_cmd_first", 64'(gpr_waddr), 64'd1);
        step();
        done_seen = 1'b0; hold_seen = 1'b0; acks = 0;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            @(negedge clk);
            if (clr_done) done_seen = 1'b1;
            else if (dbg_ack) acks++;
            if (hold_o) hold_seen = 1'b1;
            step();
        end
        idle();
        chk("clr_cmd_done", 64'(done_seen), 64'd1);
        chk("no_dbg_in_clear", 64'(acks), 64'd0);
        chk("hold_in_clear", 64'(hold_seen), 64'd1);
        step();

        // Clear paused by 3 WB writes at clr_ptr=10
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        n_we = 0; n_wb = 0; done_at = 0; resume_addr = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c >= 10 && c <= 12) begin
                RegWrite_WB = 1'b1; rd_wb = 5'd5; rd_wb_data = 32'hDEADBEEF;
            end else begin
                RegWrite_WB = 1'b0; rd_wb = '0; rd_wb_data = '0;
            end
            @(negedge clk);
            if (c >= 2 && done_at == 0) begin
                if (gpr_we) n_we++;
                if (gpr_we && gpr_waddr == 5'd5 && gpr_wdata == 32'hDEADBEEF) n_wb++;
                if (clr_done) done_at = c - 1;
            end
            if (c == 14) resume_addr = int'(gpr_waddr);
            step();
        end
        idle();
        chk("pause_wb_writes", 64'(n_wb), 64'd3);
        chk("pause_resume_addr", 64'(resume_addr), 64'd10);
        chk("pause_pass_len", 64'(done_at), 64'd34);
        chk("pause_total_writes", 64'(n_we), 64'd34);

        // Reset asserted while clr_ptr=20
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (19) step();
        rst_n = 1'b0;
        dbg_req = 1'b1; dbg_addr = 5'd4; dbg_wdata = 32'h44444444;
        @(negedge clk);
        chk("pre_reset_ptr", 64'(gpr_waddr), 64'd19);
        chk("rst_dbg_ack", 64'(dbg_ack), 64'd0);
        step();
        @(negedge clk);
        chk("midrst_we", 64'(gpr_we), 64'd0);
        chk("midrst_waddr", 64'(gpr_waddr), 64'd0);
        chk("midrst_wdata", 64'(gpr_wdata), 64'd0);
        chk("midrst_done", 64'(clr_done), 64'd0);
        chk("midrst_hold", 64'(hold_o), 64'd0);
        step();
        idle();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("restart_we", 64'(gpr_we), 64'd1);
        chk("restart_waddr", 64'(gpr_waddr), 64'd1);
        step();
        @(negedge clk);
        chk("restart_waddr2", 64'(gpr_waddr), 64'd2);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
